// File: rtl/exec_mem_hilo.sv
// exec_mem_hilo: execute/memory slice of the single-cycle MIPS core.
// ALU, HI/LO multiply/divide unit, byte-maskable data RAM and the
// register-file write-back triple. The write-back path is combinational;
// only the RAM and the HI/LO pair hold state.
// Optional feature macro: EXU_MULDIV_EN enables MULT/MULTU/DIV/DIVU.
// Without it those op codes behave as NOP and no multiplier or divider
// is built. MTHI/MTLO/MFHI/MFLO work in both builds.
module exec_mem_hilo #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned MEM_AW    = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op_i,
   input  logic [31:0] regaData_i,
   input  logic [31:0] regbData_i,
   input  logic [31:0] rt_data_i,
   input  logic        regcWr_i,
   input  logic [4:0]  regcAddr_i,
   input  logic        memWr_i,
   input  logic        memRr_i,
   input  logic [3:0]  w_mask_i,
   input  logic [3:0]  r_mask_i,
   output logic        wbWr,
   output logic [4:0]  wbAddr,
   output logic [31:0] wbData,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned DW    = 32;
   localparam int unsigned LANES = 4;

   typedef enum logic [5:0] {
      OP_NOP   = 6'h00,
      OP_ADD   = 6'h01,
      OP_SUB   = 6'h02,
      OP_AND   = 6'h03,
      OP_OR    = 6'h04,
      OP_XOR   = 6'h05,
      OP_NOR   = 6'h06,
      OP_SLT   = 6'h07,
      OP_SLTU  = 6'h08,
      OP_SLL   = 6'h09,
      OP_SRL   = 6'h0A,
      OP_SRA   = 6'h0B,
      OP_LUI   = 6'h0C,
      OP_MULT  = 6'h0D,
      OP_MULTU = 6'h0E,
      OP_DIV   = 6'h0F,
      OP_DIVU  = 6'h10,
      OP_MFHI  = 6'h11,
      OP_MFLO  = 6'h12,
      OP_MTHI  = 6'h13,
      OP_MTLO  = 6'h14,
      OP_MEM   = 6'h15
   } op_e;

   op_e                op;
   logic [DW-1:0]      opa;
   logic [DW-1:0]      opb;
   logic [4:0]         shamt;

   logic [DW-1:0]      hi_q, hi_d;
   logic [DW-1:0]      lo_q, lo_d;

   logic [DW-1:0]      mem_q [MEM_WORDS];
   logic [DW-1:0]      mem_addr;
   logic [MEM_AW-1:0]  mem_idx;
   logic [DW-1:0]      rd_word;
   logic [DW-1:0]      rd_lane_mask;
   logic [DW-1:0]      ld_data;
   logic [DW-1:0]      st_data;

   logic [DW-1:0]      alu_res;
   logic               wr_block;

   // Lowest set lane of a byte mask; an empty mask maps to lane 3, which is
   // harmless because an empty mask selects and writes nothing.
   function automatic logic [1:0] low_lane(input logic [LANES-1:0] m);
      logic [1:0] k;
      if (m[0])      k = 2'd0;
      else if (m[1]) k = 2'd1;
      else if (m[2]) k = 2'd2;
      else           k = 2'd3;
      return k;
   endfunction

   assign op       = op_e'(op_i);
   assign opa      = regaData_i;
   assign opb      = regbData_i;
   assign shamt    = opa[4:0];

   // Address generation; the byte offset and bits above the RAM are dropped.
   assign mem_addr = opa + opb;
   assign mem_idx  = MEM_AW'(mem_addr >> 2);

`ifdef EXU_MULDIV_EN
   logic [2*DW-1:0]    prod_s;
   logic [2*DW-1:0]    prod_u;
   logic [DW-1:0]      quot_s, rem_s;
   logic [DW-1:0]      quot_u, rem_u;
   logic               div_zero;

   // Multiplier and divider; divide results are only consumed when B != 0.
   always_comb begin
      prod_s   = $signed({{DW{opa[DW-1]}}, opa}) * $signed({{DW{opb[DW-1]}}, opb});
      prod_u   = {{DW{1'b0}}, opa} * {{DW{1'b0}}, opb};
      div_zero = (opb == '0);
      quot_s   = '0;
      rem_s    = '0;
      quot_u   = '0;
      rem_u    = '0;
      if (!div_zero) begin
         quot_s = DW'($signed(opa) / $signed(opb));
         rem_s  = DW'($signed(opa) % $signed(opb));
         quot_u = opa / opb;
         rem_u  = opa % opb;
      end
   end
`endif

   // ALU result, HI/LO next state and write-back suppression per op code.
   always_comb begin
      alu_res  = '0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      wr_block = 1'b0;
      case (op)
         OP_ADD:  alu_res = opa + opb;
         OP_SUB:  alu_res = opa - opb;
         OP_AND:  alu_res = opa & opb;
         OP_OR:   alu_res = opa | opb;
         OP_XOR:  alu_res = opa ^ opb;
         OP_NOR:  alu_res = ~(opa | opb);
         OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(opa) < $signed(opb))};
         OP_SLTU: alu_res = {{(DW-1){1'b0}}, (opa < opb)};
         OP_SLL:  alu_res = opb << shamt;
         OP_SRL:  alu_res = opb >> shamt;
         OP_SRA:  alu_res = DW'($signed(opb) >>> shamt);
         OP_LUI:  alu_res = {opb[15:0], 16'h0000};
`ifdef EXU_MULDIV_EN
         OP_MULT: begin
            wr_block = 1'b1;
            hi_d     = prod_s[2*DW-1:DW];
            lo_d     = prod_s[DW-1:0];
         end
         OP_MULTU: begin
            wr_block = 1'b1;
            hi_d     = prod_u[2*DW-1:DW];
            lo_d     = prod_u[DW-1:0];
         end
         OP_DIV: begin
            wr_block = 1'b1;
            if (!div_zero) begin
               hi_d = rem_s;
               lo_d = quot_s;
            end
         end
         OP_DIVU: begin
            wr_block = 1'b1;
            if (!div_zero) begin
               hi_d = rem_u;
               lo_d = quot_u;
            end
         end
`endif
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         OP_MTHI: begin
            wr_block = 1'b1;
            hi_d     = opa;
         end
         OP_MTLO: begin
            wr_block = 1'b1;
            lo_d     = opa;
         end
         OP_MEM:  alu_res = mem_addr;
         default: wr_block = 1'b1;
      endcase
   end

   // Store data aligned to the lowest enabled lane.
   always_comb begin
      st_data = rt_data_i << {low_lane(w_mask_i), 3'b000};
   end

   // Combinational load: mask the word, then shift the lowest lane to bit 0.
   always_comb begin
      rd_word      = mem_q[mem_idx];
      rd_lane_mask = '0;
      for (int l = 0; l < LANES; l++) begin
         rd_lane_mask[8*l +: 8] = {8{r_mask_i[l]}};
      end
      ld_data = (rd_word & rd_lane_mask) >> {low_lane(r_mask_i), 3'b000};
   end

   // Write-back triple, held quiet during reset.
   always_comb begin
      wbWr   = 1'b0;
      wbAddr = '0;
      wbData = '0;
      if (!rst) begin
         wbWr   = regcWr_i & ~wr_block;
         wbAddr = regcAddr_i;
         wbData = memRr_i ? ld_data : alu_res;
      end
   end

   // HI/LO pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Byte-lane RAM write; contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && memWr_i) begin
         for (int l = 0; l < LANES; l++) begin
            if (w_mask_i[l]) begin
               mem_q[mem_idx][8*l +: 8] <= st_data[8*l +: 8];
            end
         end
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_exec_mem_hilo.sv
// tb_exec_mem_hilo: directed self-checking bench for exec_mem_hilo.
// Inputs change on the falling edge; combinational outputs are sampled 1
// time unit later, state written on a rising edge is seen by the next step.
// Multiply/divide expectations follow the EXU_MULDIV_EN build option.
module tb_exec_mem_hilo;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op_i;
   logic [31:0] regaData_i;
   logic [31:0] regbData_i;
   logic [31:0] rt_data_i;
   logic        regcWr_i;
   logic [4:0]  regcAddr_i;
   logic        memWr_i;
   logic        memRr_i;
   logic [3:0]  w_mask_i;
   logic [3:0]  r_mask_i;
   logic        wbWr;
   logic [4:0]  wbAddr;
   logic [31:0] wbData;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_cmp = 0;
   int n_err = 0;

   exec_mem_hilo dut (
      .clk        (clk),
      .rst        (rst),
      .op_i       (op_i),
      .regaData_i (regaData_i),
      .regbData_i (regbData_i),
      .rt_data_i  (rt_data_i),
      .regcWr_i   (regcWr_i),
      .regcAddr_i (regcAddr_i),
      .memWr_i    (memWr_i),
      .memRr_i    (memRr_i),
      .w_mask_i   (w_mask_i),
      .r_mask_i   (r_mask_i),
      .wbWr       (wbWr),
      .wbAddr     (wbAddr),
      .wbData     (wbData),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Apply one instruction after the falling edge and let the comb path settle.
   task automatic step(input logic r, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] rt, input logic wr,
                       input logic [4:0] ad, input logic mw, input logic mr,
                       input logic [3:0] wm, input logic [3:0] rm);
      @(negedge clk);
      rst        = r;
      op_i       = op;
      regaData_i = a;
      regbData_i = b;
      rt_data_i  = rt;
      regcWr_i   = wr;
      regcAddr_i = ad;
      memWr_i    = mw;
      memRr_i    = mr;
      w_mask_i   = wm;
      r_mask_i   = rm;
      #1;
   endtask

   logic [31:0] e_hi, e_lo;

   initial begin
      rst = 1'b1; op_i = '0; regaData_i = '0; regbData_i = '0; rt_data_i = '0;
      regcWr_i = 1'b0; regcAddr_i = '0; memWr_i = 1'b0; memRr_i = 1'b0;
      w_mask_i = '0; r_mask_i = '0;

      // Reset two cycles with a live ADD on the inputs.
      step(1, 6'h01, 32'd1, 32'd2, 0, 1, 5'd7, 0, 0, 4'h0, 4'h0);
      check("rst_wbwr", 32'(wbWr), 0);
      check("rst_wbdata", wbData, 0);
      check("rst_wbaddr", 32'(wbAddr), 0);
      step(1, 6'h01, 32'd1, 32'd2, 0, 1, 5'd7, 0, 0, 4'h0, 4'h0);

      step(0, 6'h12, 0, 0, 0, 1, 5'd3, 0, 0, 4'h0, 4'h0);
      check("mflo_rst_data", wbData, 0);
      check("mflo_rst_wr", 32'(wbWr), 1);
      check("mflo_rst_addr", 32'(wbAddr), 3);
      check("rst_hi", hi_o, 0);
      check("rst_lo", lo_o, 0);

      // ALU vectors.
      step(0, 6'h01, 32'h7FFFFFFF, 32'd1, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("add_wrap", wbData, 32'h80000000);
      step(0, 6'h07, 32'hFFFFFFFF, 32'd1, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("slt", wbData, 1);
      step(0, 6'h08, 32'hFFFFFFFF, 32'd1, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("sltu", wbData, 0);
      step(0, 6'h0B, 32'd4, 32'h80000000, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("sra", wbData, 32'hF8000000);
      step(0, 6'h0A, 32'd4, 32'h80000000, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("srl", wbData, 32'h08000000);
      step(0, 6'h09, 32'h24, 32'h1, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("sll_amt5", wbData, 32'h10);
      step(0, 6'h02, 32'd5, 32'd7, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("sub", wbData, 32'hFFFFFFFE);
      step(0, 6'h06, 32'h0F0F0000, 32'h00000F0F, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("nor", wbData, 32'hF0F0F0F0);
      step(0, 6'h05, 32'hFF00FF00, 32'h0FF00FF0, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("xor", wbData, 32'hF0F0F0F0);
      step(0, 6'h0C, 0, 32'hABCD1234, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("lui", wbData, 32'h12340000);
      step(0, 6'h3F, 32'd1, 32'd1, 0, 1, 5'd4, 0, 0, 4'h0, 4'h0);
      check("illegal_wr", 32'(wbWr), 0);
      check("illegal_data", wbData, 0);

      // Multiply / divide chain.
      step(0, 6'h0D, 32'hFFFFFFFE, 32'd3, 0, 1, 5'd2, 0, 0, 4'h0, 4'h0);
      check("mult_wr", 32'(wbWr), 0);
`ifdef EXU_MULDIV_EN
      e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFFA;
`else
      e_hi = 0; e_lo = 0;
`endif
      step(0, 6'h12, 0, 0, 0, 1, 5'd2, 0, 0, 4'h0, 4'h0);
      check("mult_hi", hi_o, e_hi);
      check("mult_lo", lo_o, e_lo);
      check("mflo_after_mult", wbData, e_lo);
      step(0, 6'h10, 32'd7, 32'd2, 0, 1, 5'd2, 0, 0, 4'h0, 4'h0);
      check("divu_wr", 32'(wbWr), 0);
`ifdef EXU_MULDIV_EN
      e_hi = 1; e_lo = 3;
`endif
      step(0, 6'h10, 32'd9, 32'd0, 0, 1, 5'd2, 0, 0, 4'h0, 4'h0);
      check("divu_hi", hi_o, e_hi);
      check("divu_lo", lo_o, e_lo);
      step(0, 6'h0F, 32'hFFFFFFF9, 32'd2, 0, 1, 5'd2, 0, 0, 4'h0, 4'h0);
      check("div0_hi", hi_o, e_hi);
      check("div0_lo", lo_o, e_lo);
`ifdef EXU_MULDIV_EN
      e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFFD;
`endif
      step(0, 6'h11, 0, 0, 0, 1, 5'd2, 0, 0, 4'h0, 4'h0);
      check("div_hi", hi_o, e_hi);
      check("div_lo", lo_o, e_lo);
      check("mfhi_div", wbData, e_hi);

      // Memory: full-word store, byte store into lane 2, masked loads.
      step(0, 6'h15, 32'h100, 0, 32'h11223344, 0, 5'd0, 1, 0, 4'hF, 4'h0);
      step(0, 6'h15, 32'h100, 0, 32'h000000AB, 0, 5'd0, 1, 0, 4'h4, 4'h0);
      step(0, 6'h15, 32'h100, 0, 0, 1, 5'd5, 0, 1, 4'h0, 4'hF);
      check("ld_word", wbData, 32'h11AB3344);
      check("ld_wr", 32'(wbWr), 1);
      check("ld_addr", 32'(wbAddr), 5);
      step(0, 6'h15, 32'h100, 0, 0, 1, 5'd5, 0, 1, 4'h0, 4'hC);
      check("ld_hi_half", wbData, 32'h000011AB);
      step(0, 6'h15, 32'h100, 32'h1000, 0, 1, 5'd5, 0, 1, 4'h0, 4'h1);
      check("ld_wrap_b0", wbData, 32'h00000044);
      step(0, 6'h15, 32'h0FC, 32'd4, 0, 1, 5'd5, 0, 1, 4'h0, 4'h2);
      check("ld_b1", wbData, 32'h00000033);
      step(0, 6'h15, 32'h100, 0, 32'h00000055, 1, 5'd5, 1, 1, 4'h1, 4'h1);
      check("rw_same_cycle", wbData, 32'h00000044);
      step(0, 6'h15, 32'h100, 0, 0, 1, 5'd5, 0, 1, 4'h0, 4'h1);
      check("ld_after_rw", wbData, 32'h00000055);

      // Moves to HI/LO.
      step(0, 6'h13, 32'hDEADBEEF, 0, 0, 1, 5'd9, 0, 0, 4'h0, 4'h0);
      check("mthi_wr", 32'(wbWr), 0);
      step(0, 6'h11, 0, 0, 0, 1, 5'd9, 0, 0, 4'h0, 4'h0);
      check("mfhi", wbData, 32'hDEADBEEF);
      step(0, 6'h14, 32'h0BADF00D, 0, 0, 1, 5'd9, 0, 0, 4'h0, 4'h0);
      check("mtlo_wr", 32'(wbWr), 0);
      step(0, 6'h12, 0, 0, 0, 1, 5'd9, 0, 0, 4'h0, 4'h0);
      check("mflo", wbData, 32'h0BADF00D);

      // Reset during a store: no write, HI/LO cleared.
      step(1, 6'h15, 32'h100, 0, 32'hFFFFFFFF, 1, 5'd6, 1, 0, 4'hF, 4'h0);
      check("rst_store_wr", 32'(wbWr), 0);
      step(0, 6'h15, 32'h100, 0, 0, 1, 5'd6, 0, 1, 4'h0, 4'hF);
      check("rst_store_ram", wbData, 32'h11AB3355);
      check("rst2_hi", hi_o, 0);
      check("rst2_lo", lo_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/exec_mem_hilo.md
Name: exec_mem_hilo

Overview:
Execute/memory slice of the single-cycle MIPS core. The block takes decoded operands from the decode stage and does four things:
- ALU operations.
- Multiply/divide into an internal HI/LO register pair, plus moves to and from HI/LO.
- Computes load/store addresses and accesses a byte-maskable data RAM.
- Delivers the write-back triple (data, address, enable) to the register-file write port.

Parameters:
- MEM_WORDS, 1024, data RAM depth in 32-bit words (power of two).
- MEM_AW, 10, log2(MEM_WORDS); RAM word index is memAddr[MEM_AW+1:2].

Ports:
- clk  in  1  system clock; RAM, HI and LO update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_i  in  6  operation code (see Behaviour).
- regaData_i  in  32  operand A (rs, or shift amount).
- regbData_i  in  32  operand B (rt or immediate).
- rt_data_i  in  32  store data (rt contents).
- regcWr_i  in  1  instruction writes a register.
- regcAddr_i  in  5  destination register.
- memWr_i  in  1  store.
- memRr_i  in  1  load.
- w_mask_i  in  4  store byte-lane mask.
- r_mask_i  in  4  load byte-lane mask.
- wbWr  out  1  register write enable.
- wbAddr  out  5  register write address.
- wbData  out  32  register write data.
- hi_o  out  32  current HI (debug).
- lo_o  out  32  current LO (debug).

Behaviour:
- Datapath is combinational from inputs to wb* outputs. Only RAM, HI and LO are state and change at the clk rising edge.
- While rst=1: wbWr=0, wbData=0, wbAddr=0, no RAM write. HI and LO load 0 on the edge. RAM contents are not cleared.
- Otherwise wbAddr=regcAddr_i, and wbWr=regcWr_i except for MULT/DIV/MTHI/MTLO/NOP, which force wbWr=0.
- Op codes (A=regaData_i, B=regbData_i, wbData result):
  - 00 NOP: result 0.
  - 01 ADD: A+B, wrap, no overflow trap.
  - 02 SUB: A-B.
  - 03 AND, 04 OR, 05 XOR, 06 NOR: bitwise on A, B.
  - 07 SLT: signed A<B gives 1, else 0.
  - 08 SLTU: unsigned A<B gives 1, else 0.
  - 09 SLL: B<<A[4:0].
  - 0A SRL: B>>A[4:0], logical.
  - 0B SRA: B>>A[4:0], arithmetic.
  - 0C LUI: {B[15:0],16'h0}.
  - 0D MULT: signed A*B; {HI,LO} gets the 64-bit product.
  - 0E MULTU: unsigned A*B; {HI,LO} gets the 64-bit product.
  - 0F DIV: signed; LO gets quotient, HI gets remainder (remainder takes sign of dividend).
  - 10 DIVU: unsigned; LO gets quotient, HI gets remainder.
  - 11 MFHI: result HI. 12 MFLO: result LO.
  - 13 MTHI: HI gets A. 14 MTLO: LO gets A.
  - 15 MEM: address A+B (load/store).
  - Any other code behaves as NOP.
- Divide by zero (DIV/DIVU with B=0): HI and LO unchanged, no error flag.
- HI/LO reads are combinational from the current register. A MULT followed by MFLO in the next cycle returns the new product.
- Store (memWr_i=1, op MEM):
  - Let k be the lowest set bit of w_mask_i.
  - Write data = rt_data_i << 8k.
  - On the edge, only lanes whose mask bit is 1 are written.
  - w_mask_i=0 means no write.
- Load (memRr_i=1, op MEM):
  - The RAM word is read combinationally.
  - Let k be the lowest set bit of r_mask_i.
  - Result = (word & lane mask) >> 8k, zero-extended; wbData takes this value.
- Legal masks are 0001, 0010, 0100, 1000, 0011, 1100, 1111. Others are undefined.
- addr[1:0] is ignored for indexing; masks arrive already aligned by the decode stage.
- Address bits above MEM_AW+1 are ignored, so addresses wrap modulo RAM size.
- memWr_i and memRr_i both high: the write happens, and the load returns pre-edge data.
- memWr_i or memRr_i high with op other than MEM: the memory access is still performed using address A+B.

Optional Feature:
- Macro EXU_MULDIV_EN.
- Defined: ops 0D-10 are implemented as above.
- Undefined: ops 0D-10 act as NOP, HI/LO are not written by them, and no multiplier or divider is synthesized. MTHI, MTLO, MFHI and MFLO still work.

Test Plan:
- Reset for 2 cycles, then op=12 MFLO with regcWr_i=1, regcAddr_i=3 -> wbData=0, wbWr=1, wbAddr=3; hi_o=lo_o=0.
- op=01 A=0x7FFFFFFF B=1 -> wbData=0x80000000. op=07 A=0xFFFFFFFF B=1 -> 1. op=08, same operands -> 0. op=0B A=4 B=0x80000000 -> 0xF8000000.
- op=0D A=0xFFFFFFFE (-2), B=3 -> next cycle hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA. Then op=10 A=7 B=2 -> hi_o=1, lo_o=3. Then op=10 B=0 -> HI/LO unchanged.
- Store op=15 A=0x100 B=0 rt=0x11223344 w_mask=1111. Then store rt=0xAB with w_mask=0100. Then load r_mask=1111 -> wbData=0x11AB3344. Load r_mask=1100 -> 0x000011AB.
- op=13 A=0xDEADBEEF -> wbWr=0. Next cycle op=11 -> wbData=0xDEADBEEF.
- Assert rst during a store cycle -> RAM word unchanged, wbWr=0, HI/LO=0 after the edge.
